// File: rtl/core_pkg.sv
// Shared core definitions: register address width, x0 address and
// hazard controller state encoding.
package core_pkg;

   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] X0_ADDR = '0;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module hazard_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: load-use stalls, redirect flushes and
// data-memory freezes, with saturating stall/flush perf counters.
module hazard_detection_unit #(
   parameter int REG_AW            = core_pkg::REG_AW,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int CNT_W             = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ifid_rs1_i,
   input  logic [REG_AW-1:0] ifid_rs2_i,
   input  logic              ifid_uses_rs1_i,
   input  logic              ifid_uses_rs2_i,
   input  logic              idex_mem_read_i,
   input  logic [REG_AW-1:0] idex_rd_i,
   input  logic              redirect_i,
   input  logic              mem_busy_i,
   input  logic              clear_cnt_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              idex_write_o,
   output logic              ctrl_bubble_o,
   output logic              ifid_flush_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   import core_pkg::*;

   localparam logic [3:0] LS_INIT = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

   hazard_state_t state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;

   logic hazard;
   logic pc_w, ifid_w, idex_w, bubble, flush;
   logic stall_act;
   logic stall_inc, flush_inc, cnt_clr;

   assign hazard = idex_mem_read_i
                 & (idex_rd_i != REG_AW'(X0_ADDR))
                 & ((ifid_uses_rs1_i & (ifid_rs1_i == idex_rd_i))
                  | (ifid_uses_rs2_i & (ifid_rs2_i == idex_rd_i)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_w      = 1'b1;
      ifid_w    = 1'b1;
      idex_w    = 1'b1;
      bubble    = 1'b0;
      flush     = 1'b0;
      stall_act = 1'b0;
      if (mem_busy_i) begin
         pc_w   = 1'b0;
         ifid_w = 1'b0;
         idex_w = 1'b0;
      end else if (redirect_i) begin
         // A redirect overrides any pending stall and restarts the flush.
         bubble = 1'b1;
         flush  = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FL_INIT;
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else begin
         unique case (state_q)
            LOAD_STALL: begin
               stall_act = 1'b1;
               cnt_d     = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = IDLE;
            end
            FLUSH: begin
               bubble = 1'b1;
               flush  = 1'b1;
               cnt_d  = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = IDLE;
            end
            default: begin
               if (hazard) begin
                  stall_act = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_d = LOAD_STALL;
                     cnt_d   = LS_INIT;
                  end
               end
            end
         endcase
         if (stall_act) begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_write_o    = !reset | pc_w;
   assign ifid_write_o  = !reset | ifid_w;
   assign idex_write_o  = !reset | idex_w;
   assign ctrl_bubble_o = reset & bubble;
   assign ifid_flush_o  = reset & flush;

   // Counters freeze with the pipeline while memory is busy.
   assign stall_inc = stall_act & ~mem_busy_i;
   assign flush_inc = flush & ~mem_busy_i;
   assign cnt_clr   = clear_cnt_i & ~mem_busy_i;

   hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .clr   (cnt_clr),
      .count (stall_cnt_o)
   );

   hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .clr   (cnt_clr),
      .count (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: two configurations driven in parallel
// and compared each cycle against a remaining-cycles reference model.
module tb_hazard_detection_unit;

   localparam logic [4:0] O_IDLE  = 5'b11100;
   localparam logic [4:0] O_STALL = 5'b00110;
   localparam logic [4:0] O_FLUSH = 5'b11111;
   localparam logic [4:0] O_BUSY  = 5'b00000;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mrd, redir, busy, clr;

   logic        a_pc, a_ifid, a_idex, a_bub, a_fl;
   logic [15:0] a_sc, a_fc;
   logic        b_pc, b_ifid, b_idex, b_bub, b_fl;
   logic [1:0]  b_sc, b_fc;

   int n_chk  = 0;
   int n_fail = 0;

   int m_st[2], m_fl[2], m_sc[2], m_fc[2];
   int p_l[2]   = '{1, 3};
   int p_f[2]   = '{1, 2};
   int p_max[2] = '{65535, 3};

   always #5 clk = ~clk;

   hazard_detection_unit u_a (
      .clk(clk), .reset(rst),
      .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
      .ifid_uses_rs1_i(u1), .ifid_uses_rs2_i(u2),
      .idex_mem_read_i(mrd), .idex_rd_i(rd),
      .redirect_i(redir), .mem_busy_i(busy), .clear_cnt_i(clr),
      .pc_write_o(a_pc), .ifid_write_o(a_ifid), .idex_write_o(a_idex),
      .ctrl_bubble_o(a_bub), .ifid_flush_o(a_fl),
      .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
   );

   hazard_detection_unit #(
      .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(2)
   ) u_b (
      .clk(clk), .reset(rst),
      .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
      .ifid_uses_rs1_i(u1), .ifid_uses_rs2_i(u2),
      .idex_mem_read_i(mrd), .idex_rd_i(rd),
      .redirect_i(redir), .mem_busy_i(busy), .clear_cnt_i(clr),
      .pc_write_o(b_pc), .ifid_write_o(b_ifid), .idex_write_o(b_idex),
      .ctrl_bubble_o(b_bub), .ifid_flush_o(b_fl),
      .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
   );

   function automatic bit hz();
      return mrd && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   function automatic logic [4:0] exp_out(int k);
      if (!rst) return O_IDLE;
      if (busy) return O_BUSY;
      if (redir) return O_FLUSH;
      if (m_fl[k] > 0) return O_FLUSH;
      if (m_st[k] > 0) return O_STALL;
      if (hz()) return O_STALL;
      return O_IDLE;
   endfunction

   function automatic logic [36:0] exp_v(int k);
      return {exp_out(k), 16'(m_sc[k]), 16'(m_fc[k])};
   endfunction

   function automatic logic [36:0] got(int k);
      if (k == 0)
         return {a_pc, a_ifid, a_idex, a_bub, a_fl, a_sc, a_fc};
      return {b_pc, b_ifid, b_idex, b_bub, b_fl, 14'd0, b_sc, 14'd0, b_fc};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end
   endtask

   task automatic model_step();
      logic [4:0] o;
      for (int k = 0; k < 2; k++) begin
         o = exp_out(k);
         if (!rst) begin
            m_st[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
         end else if (!busy) begin
            if (clr) begin
               m_sc[k] = 0; m_fc[k] = 0;
            end else begin
               if (o == O_STALL && m_sc[k] < p_max[k]) m_sc[k]++;
               if (o == O_FLUSH && m_fc[k] < p_max[k]) m_fc[k]++;
            end
            if (redir) begin
               m_fl[k] = p_f[k] - 1; m_st[k] = 0;
            end else if (m_fl[k] > 0) m_fl[k]--;
            else if (m_st[k] > 0) m_st[k]--;
            else if (hz()) m_st[k] = p_l[k] - 1;
         end
      end
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_in();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mrd = 0;
      redir = 0; busy = 0; clr = 0;
   endtask

   task automatic clear_counters();
      idle_in();
      clr = 1'b1;
      advance();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_in();
      model_reset();
      mrd = 1; rd = 5; rs1 = 5; u1 = 1; redir = 1;
      #3;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (got(k) !== exp_v(k)) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %h expected %h", k, got(k), exp_v(k));
         end
      end
      @(negedge clk);
      idle_in();
      rst = 1'b1;
   endtask

   task automatic test_load_use();
      clear_counters();
      mrd = 1; rd = 5; rs1 = 5; u1 = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (got(k) !== exp_v(k)) begin
               n_fail++;
               $display("FAIL load_use[%0d] c%0d: got %h expected %h",
                        k, c, got(k), exp_v(k));
            end
         end
         advance();
         idle_in();
      end
      n_chk++;
      if (a_sc !== 16'd1) begin
         n_fail++;
         $display("FAIL load_use_cnt: got %0d expected 1", a_sc);
      end
      n_chk++;
      if (b_sc !== 2'd3) begin
         n_fail++;
         $display("FAIL long_stall_cnt: got %0d expected 3", b_sc);
      end
   endtask

   task automatic test_no_stall();
      clear_counters();
      for (int c = 0; c < 2; c++) begin
         idle_in();
         mrd = 1;
         if (c == 0) begin rd = 0; rs1 = 0; u1 = 1; end
         else begin rd = 7; rs2 = 7; u2 = 0; rs1 = 3; u1 = 1; end
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (got(k) !== {O_IDLE, 32'd0}) begin
               n_fail++;
               $display("FAIL no_stall[%0d] c%0d: got %h expected %h",
                        k, c, got(k), {O_IDLE, 32'd0});
            end
         end
         advance();
      end
      idle_in();
   endtask

   task automatic test_redirect_hazard();
      clear_counters();
      mrd = 1; rd = 9; rs1 = 9; u1 = 1; redir = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (got(k) !== exp_v(k)) begin
               n_fail++;
               $display("FAIL redirect[%0d] c%0d: got %h expected %h",
                        k, c, got(k), exp_v(k));
            end
         end
         advance();
         idle_in();
      end
      n_chk++;
      if ({b_sc, b_fc} !== {2'd0, 2'd2}) begin
         n_fail++;
         $display("FAIL redirect_cnt: got %0d/%0d expected 0/2", b_sc, b_fc);
      end
   endtask

   task automatic test_busy();
      clear_counters();
      for (int c = 0; c < 8; c++) begin
         idle_in();
         if (c == 0) begin mrd = 1; rd = 4; rs2 = 4; u2 = 1; end
         busy = (c >= 1 && c <= 4);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (got(k) !== exp_v(k)) begin
               n_fail++;
               $display("FAIL busy[%0d] c%0d: got %h expected %h",
                        k, c, got(k), exp_v(k));
            end
         end
         advance();
      end
      idle_in();
      n_chk++;
      if (b_sc !== 2'd3) begin
         n_fail++;
         $display("FAIL busy_cnt: got %0d expected 3", b_sc);
      end
   endtask

   task automatic test_reset_mid_flush();
      clear_counters();
      redir = 1;
      advance();
      redir = 0;
      #1;
      n_chk++;
      if (got(1) !== exp_v(1)) begin
         n_fail++;
         $display("FAIL in_flush: got %h expected %h", got(1), exp_v(1));
      end
      #1 rst = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (got(k) !== {O_IDLE, 32'd0}) begin
            n_fail++;
            $display("FAIL mid_reset[%0d]: got %h expected %h",
                     k, got(k), {O_IDLE, 32'd0});
         end
      end
      advance();
      rst = 1'b1;
   endtask

   task automatic test_saturation();
      clear_counters();
      mrd = 1; rd = 2; rs1 = 2; u1 = 1;
      for (int c = 0; c < 5; c++) advance();
      idle_in();
      #1;
      n_chk++;
      if (b_sc !== 2'd3 || a_sc !== 16'd5) begin
         n_fail++;
         $display("FAIL saturate: got %0d/%0d expected 3/5", b_sc, a_sc);
      end
      clr = 1;
      advance();
      clr = 0;
      #1;
      n_chk++;
      if (b_sc !== 2'd0 || a_sc !== 16'd0) begin
         n_fail++;
         $display("FAIL clear: got %0d/%0d expected 0/0", b_sc, a_sc);
      end
   endtask

   task automatic test_random();
      clear_counters();
      for (int c = 0; c < 400; c++) begin
         rs1   = 5'($urandom_range(0, 3));
         rs2   = 5'($urandom_range(0, 3));
         rd    = 5'($urandom_range(0, 3));
         u1    = 1'($urandom);
         u2    = 1'($urandom);
         mrd   = 1'($urandom);
         redir = ($urandom_range(0, 7) == 0);
         busy  = ($urandom_range(0, 7) == 0);
         clr   = ($urandom_range(0, 31) == 0);
         #1;
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (got(k) !== exp_v(k)) begin
               n_fail++;
               $display("FAIL random[%0d] c%0d: got %h expected %h",
                        k, c, got(k), exp_v(k));
            end
         end
         advance();
      end
      idle_in();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_redirect_hazard();
      test_busy();
      test_reset_mid_flush();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Pipeline hazard controller for the RISC-V core; sits in ID stage, directly upstream of the control-bundle bubble mux.
- Its ctrl_bubble_o drives that mux's selector, zeroing the control bundle entering ID/EX.
- Handles load-use stalls, taken-branch/jump redirects (Branch/Jal/Jalr resolved in EX) and data-memory busy freezes.
- Multi-cycle sequencing via FSM and down-counter; saturating performance counters.

Parameters:
- REG_AW, 5, register address width.
- LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard, including the detection cycle; legal 1..15.
- FLUSH_CYCLES, 1, total flush cycles per redirect, including the detection cycle; legal 1..15.
- CNT_W, 16, performance counter width.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- ifid_rs1_i  input  REG_AW  rs1 of instruction in ID
- ifid_rs2_i  input  REG_AW  rs2 of instruction in ID
- ifid_uses_rs1_i  input  1  ID instruction reads rs1
- ifid_uses_rs2_i  input  1  ID instruction reads rs2
- idex_mem_read_i  input  1  MemRead of instruction in EX
- idex_rd_i  input  REG_AW  rd of instruction in EX
- redirect_i  input  1  EX resolved taken Branch/Jal/Jalr
- mem_busy_i  input  1  data memory not ready; freeze pipeline
- clear_cnt_i  input  1  synchronous clear of perf counters
- pc_write_o  output  1  PC register enable
- ifid_write_o  output  1  IF/ID register enable
- idex_write_o  output  1  ID/EX register enable
- ctrl_bubble_o  output  1  selector to the control bubble mux (1 = zero controls)
- ifid_flush_o  output  1  clear IF/ID to NOP
- stall_cnt_o  output  CNT_W  saturating count of load-use stall cycles
- flush_cnt_o  output  CNT_W  saturating count of flush cycles

Behaviour:
- Registered state: fsm ∈ {IDLE, LOAD_STALL, FLUSH}, cnt[3:0], two perf counters. Outputs are combinational from state plus current inputs.
- Reset low (async): fsm=IDLE, cnt=0, counters=0. While reset low, outputs are forced: pc_write_o=1, ifid_write_o=1, idex_write_o=1, ctrl_bubble_o=0, ifid_flush_o=0.
- hazard = idex_mem_read_i & (idex_rd_i!=0) & ((ifid_uses_rs1_i & ifid_rs1_i==idex_rd_i) | (ifid_uses_rs2_i & ifid_rs2_i==idex_rd_i)).
- Priority, highest first: mem_busy_i, redirect_i, current state, hazard.
- mem_busy_i=1:
  - pc/ifid/idex write=0; bubble=0; flush=0.
  - fsm, cnt and counters hold.
  - Upstream keeps redirect_i asserted while frozen.
- redirect_i=1, any state:
  - pc_write_o=1, ifid_write_o=1, idex_write_o=1, ifid_flush_o=1, ctrl_bubble_o=1.
  - If FLUSH_CYCLES>1: fsm←FLUSH, cnt←FLUSH_CYCLES-1. Otherwise fsm←IDLE.
  - Aborts any pending load stall; re-asserting redirect in FLUSH restarts the count.
- IDLE, no redirect, hazard:
  - pc_write_o=0, ifid_write_o=0, idex_write_o=1, ctrl_bubble_o=1.
  - If LOAD_STALL_CYCLES>1: fsm←LOAD_STALL, cnt←LOAD_STALL_CYCLES-1.
- IDLE, nothing pending: all writes=1, bubble=0, flush=0.
- LOAD_STALL (no redirect):
  - Same outputs as hazard stall.
  - cnt←cnt-1; when cnt==1, fsm←IDLE.
  - Hazard inputs are ignored in this state.
- FLUSH (no redirect):
  - Same outputs as redirect.
  - cnt←cnt-1; when cnt==1, fsm←IDLE.
- Perf counters:
  - stall_cnt_o +1 on every non-busy cycle with a load stall asserted.
  - flush_cnt_o +1 on every non-busy cycle with ifid_flush_o asserted.
  - Both saturate at 2^CNT_W-1.
  - clear_cnt_i sets both to 0 and wins over increment in the same cycle.
- Latency: hazard and redirect response is same-cycle (combinational); state advances on the clk rising edge.
- Simultaneous hazard and redirect: redirect only; no stall is counted.
- Reset mid-stall or mid-flush: immediate return to IDLE and counters cleared.

Decomposition:
- Shared package core_pkg:
  - hazard_state_t enum {IDLE=2'd0, LOAD_STALL=2'd1, FLUSH=2'd2}
  - REG_AW constant
  - X0_ADDR constant (0)
- Sub-module hazard_sat_counter: parameter W; ports clk, reset, inc, clr, count. Instantiated twice.

Test Plan:
- Load-use hazard: idex_mem_read_i=1, idex_rd_i=5, ifid_rs1_i=5, uses_rs1=1, default params → one cycle of pc_write_o=0, ifid_write_o=0, ctrl_bubble_o=1; next cycle all writes 1; stall_cnt_o=1.
- rd=x0 or uses_rs2=0 with rs2 match → no stall; outputs stay at idle values.
- LOAD_STALL_CYCLES=3 with a one-cycle hazard pulse → exactly 3 stall cycles, then IDLE; stall_cnt_o=3.
- FLUSH_CYCLES=2, redirect_i pulsed in the same cycle as a hazard → 2 cycles of ifid_flush_o=1 and ctrl_bubble_o=1 with pc_write_o=1; stall_cnt_o=0; flush_cnt_o=2.
- mem_busy_i=1 for 4 cycles in the middle of LOAD_STALL_CYCLES=3 → all writes 0 and counters frozen; stall resumes with the remaining count after busy drops.
- Reset driven low during FLUSH → outputs immediately at idle values and counters 0. CNT_W=2 with 5 stall cycles → stall_cnt_o saturates at 3; clear_cnt_i → 0.
